spike_cache_responder: RTL and testbench



---
 rtl/spike_cache_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_spike_cache_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_cache_responder.sv
// spike_cache_responder
//   Memory-side partner of the SNN core's spike interface. Tile-packed spike
//   words from the core are staged in a small FIFO. A serializer then compacts
//   the non-empty lanes into per-timestep spike lists. Two banks ping-pong, so
//   one layer's outputs can be written while the previous layer's spikes are read.
//
// Ports
//   clk, reset         clock; synchronous active-low reset
//   wr_valid           push {wr_time, wr_spikes} into the staging FIFO
//   wr_spikes          size_tile lanes of size_spike bits; a zero lane is empty
//   wr_time            timestep of the pushed word
//   bank_swap          pulse; swap the read/write banks once the write side is idle
//   rd_load            level load request; answered by a single mem_ready pulse
//   rd_time, rd_addr   read timestep / list index
//   out_spike          registered spike at rd_time/rd_addr in the read bank (0 = none)
//   out_spike_limit    registered count-1 for rd_time (0 when the list is empty)
//   mem_ready          one-cycle load acknowledge
//   busy               FIFO non-empty or serializer mid-word
//   overflow           sticky; a word or a spike was dropped
//
// Build option
//   SPIKE_DEDUP_EN     when defined, skip a lane equal to the most recently stored
//                      entry of the same bank/timestep
module spike_cache_responder #(
  parameter int unsigned size_tile      = 4,
  parameter int unsigned size_spike     = 10,
  parameter int unsigned num_timesteps  = 10,
  parameter int unsigned size_spike_max = 512,
  parameter int unsigned fifo_depth     = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_valid,
  input  logic [size_spike*size_tile-1:0]    wr_spikes,
  input  logic [$clog2(num_timesteps)-1:0]   wr_time,
  input  logic                               bank_swap,
  input  logic                               rd_load,
  input  logic [$clog2(num_timesteps)-1:0]   rd_time,
  input  logic [$clog2(size_spike_max)-1:0]  rd_addr,
  output logic [size_spike-1:0]              out_spike,
  output logic [size_spike-1:0]              out_spike_limit,
  output logic                               mem_ready,
  output logic                               busy,
  output logic                               overflow
);

  localparam int unsigned TimeW  = $clog2(num_timesteps);
  localparam int unsigned AddrW  = $clog2(size_spike_max);
  localparam int unsigned CntW   = $clog2(size_spike_max + 1);
  localparam int unsigned LaneW  = (size_tile > 1) ? $clog2(size_tile) : 1;
  localparam int unsigned PtrW   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned WordW  = size_spike * size_tile;
  localparam int unsigned EntryW = TimeW + WordW;

  localparam logic [TimeW-1:0] LastT   = TimeW'(num_timesteps - 1);
  localparam logic [CntW-1:0]  CntMax  = CntW'(size_spike_max);
  localparam logic [LaneW-1:0] LastLn  = LaneW'(size_tile - 1);
  localparam logic [PtrW:0]    FifoMax = (PtrW + 1)'(fifo_depth);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StReady = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  // Staging FIFO
  logic [EntryW-1:0] fifo_mem [fifo_depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     fifo_cnt_q;

  // Serializer
  logic             ser_active_q;
  logic [LaneW-1:0] lane_q;
  logic [WordW-1:0] word_q;
  logic [TimeW-1:0] word_time_q;

  // Spike lists
  logic [size_spike-1:0] mem [2][num_timesteps][size_spike_max];
  logic [CntW-1:0]       cnt_q [2][num_timesteps];
  logic                  wbank_q;
  logic                  rbank;

  logic                  swap_pending_q;
  logic                  overflow_q;
  logic [1:0]            state_q, state_d;
  logic [size_spike-1:0] out_spike_q, out_limit_q;

  logic                  fifo_empty, fifo_full;
  logic                  wr_time_ok, rd_time_ok;
  logic                  pop, push_ok, push_drop;
  logic [EntryW-1:0]     head;
  logic                  cur_valid;
  logic [TimeW-1:0]      cur_time;
  logic [size_spike-1:0] cur_spike;
  logic [CntW-1:0]       cur_cnt;
  logic                  cnt_full, dup, do_store, spike_drop;
  logic                  swap_go;
  logic [CntW-1:0]       rd_cnt;
  logic                  rd_hit;

  assign rbank      = ~wbank_q;
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == FifoMax);
  assign wr_time_ok = (wr_time <= LastT);
  assign rd_time_ok = (rd_time <= LastT);

  // Lane 0 is handled in the pop cycle straight from the FIFO head, so a new word
  // is taken every size_tile cycles.
  assign pop       = !ser_active_q && !fifo_empty;
  assign push_ok   = wr_valid && wr_time_ok && (!fifo_full || pop);
  assign push_drop = wr_valid && !push_ok;
  assign head      = fifo_mem[rd_ptr_q];

  always_comb begin
    cur_valid = pop || ser_active_q;
    cur_time  = word_time_q;
    cur_spike = word_q[lane_q*size_spike +: size_spike];
    if (pop) begin
      cur_time  = head[EntryW-1 -: TimeW];
      cur_spike = head[size_spike-1:0];
    end
  end

  assign cur_cnt = cnt_q[wbank_q][cur_time];
  assign cnt_full = (cur_cnt == CntMax);

`ifdef SPIKE_DEDUP_EN
  // Only consulted while the count is non-zero, so clearing a count also clears
  // the dedup history.
  logic [size_spike-1:0] last_q [2][num_timesteps];

  always_ff @(posedge clk) begin
    if (do_store) last_q[wbank_q][cur_time] <= cur_spike;
  end

  assign dup = (cur_cnt != '0) && (last_q[wbank_q][cur_time] == cur_spike);
`else
  assign dup = 1'b0;
`endif

  assign do_store   = reset && cur_valid && (cur_spike != '0) && !cnt_full && !dup;
  assign spike_drop = cur_valid && (cur_spike != '0) && cnt_full;

  assign busy    = !fifo_empty || ser_active_q;
  assign swap_go = swap_pending_q && !busy && !wr_valid;

  assign rd_cnt = rd_time_ok ? cnt_q[rbank][rd_time] : '0;
  assign rd_hit = rd_time_ok && (CntW'(rd_addr) < rd_cnt);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {wr_time, wr_spikes};
    if (do_store) mem[wbank_q][cur_time][cur_cnt[AddrW-1:0]] <= cur_spike;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_cnt_q     <= '0;
      ser_active_q   <= 1'b0;
      lane_q         <= '0;
      word_q         <= '0;
      word_time_q    <= '0;
      wbank_q        <= 1'b0;
      swap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
      out_spike_q    <= '0;
      out_limit_q    <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int t = 0; t < int'(num_timesteps); t++) cnt_q[b][t] <= '0;
      end
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!push_ok && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;

      if (pop) begin
        word_q       <= head[WordW-1:0];
        word_time_q  <= head[EntryW-1 -: TimeW];
        lane_q       <= LaneW'(1);
        ser_active_q <= (size_tile > 1);
      end else if (ser_active_q) begin
        lane_q <= lane_q + 1'b1;
        if (lane_q == LastLn) ser_active_q <= 1'b0;
      end

      if (do_store) cnt_q[wbank_q][cur_time] <= cur_cnt + 1'b1;

      if (swap_go) begin
        wbank_q        <= ~wbank_q;
        swap_pending_q <= 1'b0;
        for (int t = 0; t < int'(num_timesteps); t++) cnt_q[rbank][t] <= '0;
      end else if (bank_swap) begin
        swap_pending_q <= 1'b1;
      end

      overflow_q <= overflow_q | push_drop | spike_drop;

      out_spike_q <= rd_hit ? mem[rbank][rd_time][rd_addr] : '0;
      out_limit_q <= (rd_cnt != '0) ? size_spike'(rd_cnt - 1'b1) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (rd_load) state_d = StWait;
      StWait:  if (!swap_pending_q && !busy) state_d = StReady;
      StReady: state_d = StHold;
      StHold:  if (!rd_load) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  assign mem_ready       = (state_q == StReady);
  assign overflow        = overflow_q;
  assign out_spike       = out_spike_q;
  assign out_spike_limit = out_limit_q;

endmodule

// File: tb/tb_spike_cache_responder.sv
module tb_spike_cache_responder;

  localparam int unsigned SS = 10;
  localparam int unsigned ST = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_valid = 1'b0;
  logic [SS*ST-1:0] wr_spikes = '0;
  logic [3:0]    wr_time = '0;
  logic          bank_swap = 1'b0;
  logic          rd_load = 1'b0;
  logic [3:0]    rd_time = '0;
  logic [8:0]    rd_addr = '0;
  logic [SS-1:0] out_spike, out_spike_limit;
  logic          mem_ready, busy, overflow;

  spike_cache_responder dut (
    .clk             (clk),
    .reset           (reset),
    .wr_valid        (wr_valid),
    .wr_spikes       (wr_spikes),
    .wr_time         (wr_time),
    .bank_swap       (bank_swap),
    .rd_load         (rd_load),
    .rd_time         (rd_time),
    .rd_addr         (rd_addr),
    .out_spike       (out_spike),
    .out_spike_limit (out_spike_limit),
    .mem_ready       (mem_ready),
    .busy            (busy),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   ready_cnt = 0;
  int   read_id = 0;
  logic prev_ready = 1'b0;
  logic rd_strobe = 1'b0;
  int   exp_spike_q[$];
  int   exp_limit_q[$];
  int   exp_tag_q[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Monitor: samples 1 ns after each rising edge; pops read expectations whenever
  // the bench has a read strobe in flight and counts mem_ready pulses.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        check("mem_ready_single_pulse", int'(prev_ready), 0);
        check("mem_ready_while_busy", int'(busy), 0);
        ready_cnt++;
      end
      prev_ready = mem_ready;
      if (rd_strobe) begin
        if (exp_spike_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL read_unexpected: got a read with no expectation queued");
        end else begin
          int es, el, tag;
          es  = exp_spike_q.pop_front();
          el  = exp_limit_q.pop_front();
          tag = exp_tag_q.pop_front();
          check($sformatf("read%0d_spike", tag), int'(out_spike), es);
          check($sformatf("read%0d_limit", tag), int'(out_spike_limit), el);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; wr_valid = 1'b0; bank_swap = 1'b0; rd_load = 1'b0;
    rd_strobe = 1'b0; rd_time = '0; rd_addr = '0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_spike"}, int'(out_spike), 0);
    check({tag, "_limit"}, int'(out_spike_limit), 0);
    check({tag, "_mem_ready"}, int'(mem_ready), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic push_word(input int t, input int l0, input int l1, input int l2, input int l3);
    wr_time   = 4'(t);
    wr_spikes = {SS'(l3), SS'(l2), SS'(l1), SS'(l0)};
    wr_valid  = 1'b1;
    tick(1);
    wr_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin tick(1); n++; end
    check({name, "_drained"}, int'(busy), 0);
  endtask

  task automatic swap_banks();
    bank_swap = 1'b1;
    tick(1);
    bank_swap = 1'b0;
    tick(2);
  endtask

  task automatic do_load(input string name, input int exp_lat);
    int start, lat;
    start = ready_cnt;
    lat = 0;
    rd_load = 1'b1;
    while (ready_cnt == start && lat < 400) begin tick(1); lat++; end
    check({name, "_latency"}, lat, exp_lat);
    tick(4);
    check({name, "_one_pulse"}, ready_cnt - start, 1);
    rd_load = 1'b0;
    tick(1);
  endtask

  task automatic rd(input int t, input int a, input int es, input int el);
    rd_time = 4'(t);
    rd_addr = 9'(a);
    rd_strobe = 1'b1;
    exp_spike_q.push_back(es);
    exp_limit_q.push_back(el);
    exp_tag_q.push_back(read_id);
    read_id++;
    tick(1);
  endtask

  task automatic rd_done();
    rd_strobe = 1'b0;
    tick(1);
  endtask

  initial begin
    // 1: reset state and basic compaction
    do_reset();
    tick(1);
    check_outputs_zero("reset");
    swap_banks();
    push_word(2, 5, 0, 9, 0);
    wait_idle("t1");
    swap_banks();
    rd_time = 4'd2;
    do_load("t1_load", 2);
    rd(2, 0, 5, 1);
    rd(2, 1, 9, 1);
    rd(2, 2, 0, 1);
    rd(3, 0, 0, 0);
    rd(12, 0, 0, 0);
    rd_done();

    // 2: FIFO overflow; words 0..5 are accepted, 6 and 7 are dropped
    do_reset();
    for (int i = 0; i < 8; i++) push_word(1, 10 + i, 0, 0, 0);
    check("t2_overflow", int'(overflow), 1);
    check("t2_busy_draining", int'(busy), 1);
    wait_idle("t2");
    swap_banks();
    do_load("t2_load", 2);
    for (int a = 0; a < 6; a++) rd(1, a, 10 + a, 5);
    rd(1, 6, 0, 5);
    rd_done();

    // 3: load right after a swap with 3 words queued waits for drain plus swap
    do_reset();
    swap_banks();
    push_word(4, 21, 22, 0, 0);
    push_word(4, 0, 0, 23, 0);
    push_word(4, 24, 0, 0, 25);
    bank_swap = 1'b1;
    tick(1);
    bank_swap = 1'b0;
    do_load("t3_load1", 11);
    do_load("t3_load2", 2);
    for (int a = 0; a < 5; a++) rd(4, a, 21 + a, 4);
    rd(4, 5, 0, 4);
    rd_done();

    // 4: list capacity; the 513th spike is dropped and the count saturates
    do_reset();
    swap_banks();
    for (int i = 0; i < 128; i++) begin
      push_word(0, 4*i + 1, 4*i + 2, 4*i + 3, 4*i + 4);
      tick(3);
    end
    wait_idle("t4_fill");
    check("t4_no_overflow_at_512", int'(overflow), 0);
    push_word(0, 7, 7, 7, 7);
    wait_idle("t4_extra");
    check("t4_overflow_past_512", int'(overflow), 1);
    swap_banks();
    do_load("t4_load", 2);
    rd(0, 0, 1, 511);
    rd(0, 255, 256, 511);
    rd(0, 511, 512, 511);
    rd_done();

    // 5: reset mid-serialization clears FIFO, counts of both banks
    do_reset();
    push_word(3, 1, 2, 3, 4);
    wait_idle("t5_prep");
    swap_banks();
    push_word(3, 5, 6, 0, 0);
    tick(1);
    do_reset();
    tick(1);
    check_outputs_zero("t5_reset");
    swap_banks();
    do_load("t5_load", 2);
    rd(3, 0, 0, 0);
    rd(0, 0, 0, 0);
    rd_done();

    // 6: repeated lanes, then an out-of-range write timestep
    do_reset();
    swap_banks();
    push_word(5, 3, 3, 4, 4);
    wait_idle("t6");
    check("t6_no_overflow", int'(overflow), 0);
    push_word(11, 8, 8, 8, 8);
    check("t6_bad_time_overflow", int'(overflow), 1);
    check("t6_bad_time_not_queued", int'(busy), 0);
    swap_banks();
    do_load("t6_load", 2);
`ifdef SPIKE_DEDUP_EN
    rd(5, 0, 3, 1);
    rd(5, 1, 4, 1);
    rd(5, 2, 0, 1);
`else
    rd(5, 0, 3, 3);
    rd(5, 1, 3, 3);
    rd(5, 2, 4, 3);
    rd(5, 3, 4, 3);
`endif
    rd_done();

    tick(2);
    check("scoreboard_drained", exp_spike_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
